// File: rtl/reg_bank_scoreboard.sv
// Dual integer/FP register bank with NREAD combinational read ports and a per-register busy scoreboard.
// Optional same-cycle writeback forwarding is enabled with `define REGFILE_BYPASS_EN.
module reg_bank_scoreboard #(
  parameter int              XLEN    = 32,
  parameter int              NREAD   = 3,
  parameter logic [XLEN-1:0] SP_INIT = 32'h2FFC,
  parameter logic [XLEN-1:0] GP_INIT = 32'h1800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*5-1:0]    rd_add,
  input  logic [NREAD-1:0]      rd_fp,
  input  logic [NREAD-1:0]      rd_en,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd_add,
  input  logic                  issue_rd_fp,
  input  logic                  issue_we,
  output logic                  issue_stall,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_add,
  input  logic                  wb_fp,
  input  logic [XLEN-1:0]       wb_data,
  output logic [6:0]            pending_cnt
);

  logic [XLEN-1:0] int_mem_reg [32];
  logic [XLEN-1:0] fp_mem_reg  [32];
  logic [31:0]     int_busy_reg;
  logic [31:0]     fp_busy_reg;
  logic [6:0]      pending_cnt_reg;

  logic [NREAD-1:0] port_hazard;
  logic             wb_write;
  logic             wb_busy;
  logic             dest_busy;
  logic             wb_dest_hit;
  logic             waw_hazard;
  logic             accept;
  logic             set_en;
  logic             cnt_inc;
  logic             cnt_dec;

  // Integer x0 is hardwired: writebacks to it never touch storage.
  assign wb_write = wb_valid & (wb_fp | (wb_add != 5'd0));

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_port
      logic [4:0]      add;
      logic            fp;
      logic            is_x0;
      logic            busy_bit;
      logic [XLEN-1:0] mem_word;

      assign add      = rd_add[5*gi +: 5];
      assign fp       = rd_fp[gi];
      assign is_x0    = !fp && (add == 5'd0);
      assign busy_bit = fp ? fp_busy_reg[add] : int_busy_reg[add];
      assign mem_word = fp ? fp_mem_reg[add] : int_mem_reg[add];

`ifdef REGFILE_BYPASS_EN
      logic wb_hit;
      // A matching writeback this cycle supplies the operand, so its busy bit no longer matters.
      assign wb_hit = wb_write && (wb_add == add) && (wb_fp == fp);
      assign rd_data[gi*XLEN +: XLEN] = is_x0 ? '0 : (wb_hit ? wb_data : mem_word);
      assign port_hazard[gi] = rd_en[gi] & busy_bit & !wb_hit;
`else
      assign rd_data[gi*XLEN +: XLEN] = is_x0 ? '0 : mem_word;
      assign port_hazard[gi] = rd_en[gi] & busy_bit;
`endif
    end
  endgenerate

  assign dest_busy   = issue_rd_fp ? fp_busy_reg[issue_rd_add] : int_busy_reg[issue_rd_add];
  assign wb_busy     = wb_fp ? fp_busy_reg[wb_add] : int_busy_reg[wb_add];
  assign wb_dest_hit = wb_write && (wb_add == issue_rd_add) && (wb_fp == issue_rd_fp);

`ifdef REGFILE_BYPASS_EN
  assign waw_hazard = issue_we & dest_busy & !wb_dest_hit;
`else
  assign waw_hazard = issue_we & dest_busy;
`endif

  assign issue_stall = issue_valid & ((|port_hazard) | waw_hazard);
  assign accept      = issue_valid & !issue_stall;
  assign set_en      = accept & issue_we & (issue_rd_fp | (issue_rd_add != 5'd0));

  // Counter tracks bit transitions: a set on an already-busy bit and a clear overridden by the issue both net to zero.
  assign cnt_inc = set_en & !dest_busy;
  assign cnt_dec = wb_valid & wb_busy & !(set_en & wb_dest_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        int_mem_reg[i] <= '0;
        fp_mem_reg[i]  <= '0;
      end
      int_mem_reg[2]  <= SP_INIT;
      int_mem_reg[3]  <= GP_INIT;
      int_busy_reg    <= '0;
      fp_busy_reg     <= '0;
      pending_cnt_reg <= '0;
    end else begin
      if (wb_write) begin
        if (wb_fp) fp_mem_reg[wb_add]  <= wb_data;
        else       int_mem_reg[wb_add] <= wb_data;
      end
      if (wb_valid) begin
        if (wb_fp) fp_busy_reg[wb_add]  <= 1'b0;
        else       int_busy_reg[wb_add] <= 1'b0;
      end
      // Placed after the clear so a same-register issue leaves the bit set.
      if (set_en) begin
        if (issue_rd_fp) fp_busy_reg[issue_rd_add]  <= 1'b1;
        else             int_busy_reg[issue_rd_add] <= 1'b1;
      end
      pending_cnt_reg <= pending_cnt_reg + 7'(cnt_inc) - 7'(cnt_dec);
    end
  end

  assign pending_cnt = pending_cnt_reg;

endmodule
